fetch_decode_unit: RTL and testbench
====================================

Name: fetch_decode_unit

Overview:
Front-end stage that sits directly upstream of the 4×16-bit register file in the single-cycle CPU.
- Owns the PC and fetches one 16-bit instruction per step from instruction memory over a read/ready handshake.
- Holds the instruction in an IR and drives the register-file read/write addresses and decoded fields to the datapath.
- Advances to the next instruction only when the execution/writeback side signals completion.

Parameters:
WORD_W, 16, width of instructions, data and addresses
RESET_PC, 16'h0000, PC value loaded on reset
HLT_FUNC, 6'd29, func code of the halt instruction (opcode 4'hF)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  reset; asynchronous, active-high (asserted = 1)
read_m  output  1  instruction memory read request
address  output  WORD_W  instruction memory address (= pc)
data  input  WORD_W  instruction memory read data
input_ready  input  1  memory data valid this cycle
ex_done  input  1  current instruction has completed execute/writeback
branch_taken  input  1  qualifies branch_target when ex_done = 1
branch_target  input  WORD_W  next PC when branch_taken = 1
instr_valid  output  1  decoded outputs describe a live instruction
opcode  output  4  ir[15:12]
func_code  output  6  ir[5:0]
read1  output  2  ir[11:10] (rs)
read2  output  2  ir[9:8] (rt)
write_reg  output  2  rd = ir[7:6] if opcode = 4'hF, else rt = ir[9:8]
imm_ext  output  WORD_W  sign-extended ir[7:0]
jmp_target  output  WORD_W  {pc[15:12], ir[11:0]}
pc  output  WORD_W  PC of the instruction in the IR
num_inst  output  WORD_W  retired-instruction counter
halted  output  1  halt instruction retired

Behaviour:
- States:
  - S_IDLE: entered on reset; one cycle; then S_FETCH.
  - S_FETCH: read_m = 1, address = pc. When input_ready = 1 in this state, latch data into ir and go to S_ISSUE on the same edge.
  - S_ISSUE: instr_valid = 1. When ex_done = 1, retire the instruction:
    - num_inst += 1 (wraps 16'hFFFF→0).
    - pc <= branch_taken ? branch_target : pc + 1 (wraps 16'hFFFF→0).
    - If opcode = 4'hF and func_code = HLT_FUNC: go to S_HALT and do not change pc. Otherwise go to S_FETCH.
  - S_HALT: halted = 1; read_m = 0; instr_valid = 0. Stays here until reset.
- read_m, instr_valid and halted are decoded from the state register only; no combinational path from inputs.
- Decoded outputs are pure functions of ir/pc. They stay stable outside S_ISSUE and are qualified only by instr_valid.
- Minimum latency: 2 cycles per instruction (input_ready on the first S_FETCH cycle, ex_done on the first S_ISSUE cycle), plus 1 cycle after reset for S_IDLE.
- input_ready is ignored outside S_FETCH. ex_done and branch_* are ignored outside S_ISSUE.
- A wait of any length is legal in S_FETCH and S_ISSUE. address and ir must hold constant throughout.
- Reset values (asynchronous, effective immediately, including mid-fetch or mid-issue):
  - state = S_IDLE, pc = RESET_PC, ir = 16'h0000, num_inst = 0.
  - Hence read_m = 0, instr_valid = 0, halted = 0, address = RESET_PC.
  - Decoded fields: opcode = 0, read1 = read2 = write_reg = 0, imm_ext = 0.
- Reset deassertion: the first S_FETCH cycle is one clk edge later.
- branch_taken = 1 together with a halt instruction: the halt takes priority and pc is unchanged.

Decomposition:
- Shared package (cpu_defs): WORD_W, opcode constants (R-type 4'hF), HLT_FUNC and other func codes, FSM state encoding (S_IDLE/S_FETCH/S_ISSUE/S_HALT), REG_ADDR_W = 2.
- One combinational sub-module, instr_decoder: ir + pc → opcode, func_code, read1, read2, write_reg, imm_ext, jmp_target.
- The FSM, pc, ir and num_inst registers stay in fetch_decode_unit.

Test Plan:
- Reset release, memory returns 16'hF1C0 with input_ready on the 1st fetch cycle:
  - read_m rises 1 cycle after reset deasserts, address = 0.
  - Next cycle: instr_valid = 1, read1 = 0, read2 = 1, write_reg = 3, opcode = F.
- ex_done with branch_taken = 0 after 3 wait cycles → pc = 1, num_inst = 1, read_m = 1, address = 1 on the following cycle.
- I-type 16'h46FE (opcode 4, rs = 1, rt = 2) → write_reg = 2, imm_ext = 16'hFFFE. With branch_taken = 1 and branch_target = 16'h0040 at ex_done → next address = 16'h0040.
- input_ready held low 5 cycles → address/read_m stable, instr_valid = 0. Stray ex_done pulses during fetch → no pc change.
- Halt 16'hF01D retired → halted = 1, read_m = 0, pc unchanged, num_inst incremented. State persists 20 cycles until reset.
- Assert reset_n mid-S_ISSUE (asynchronously, between edges) → instr_valid drops immediately, pc = RESET_PC, num_inst = 0. Pc = 16'hFFFF with ex_done → pc wraps to 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared widths, opcodes, func codes and FSM encoding for the CPU front end
package cpu_defs;

    localparam int WORD_W     = 16;
    localparam int REG_ADDR_W = 2;

    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_RTYPE = 4'hF;

    localparam logic [5:0] FUNC_ADD = 6'd0;
    localparam logic [5:0] FUNC_SUB = 6'd1;
    localparam logic [5:0] FUNC_AND = 6'd2;
    localparam logic [5:0] FUNC_OR  = 6'd3;
    localparam logic [5:0] FUNC_HLT = 6'd29;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational split of the IR into register addresses and operand fields
module instr_decoder
    import cpu_defs::*;
#(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0]     ir,
    input  logic [WORD_W-13:0]    pc_hi,
    output logic [3:0]            opcode,
    output logic [5:0]            func_code,
    output logic [REG_ADDR_W-1:0] read1,
    output logic [REG_ADDR_W-1:0] read2,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [WORD_W-1:0]     imm_ext,
    output logic [WORD_W-1:0]     jmp_target
);

    assign opcode     = ir[15:12];
    assign func_code  = ir[5:0];
    assign read1      = ir[11:10];
    assign read2      = ir[9:8];
    // R-type writes rd; every other format writes back into rt
    assign write_reg  = (ir[15:12] == OP_RTYPE) ? ir[7:6] : ir[9:8];
    assign imm_ext    = {{(WORD_W-8){ir[7]}}, ir[7:0]};
    assign jmp_target = {pc_hi, ir[11:0]};

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC/IR owner: fetches one instruction, holds it until execute retires it
module fetch_decode_unit #(
    parameter int          WORD_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [5:0]  HLT_FUNC = 6'd29
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              read_m,
    output logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] data,
    input  logic              input_ready,
    input  logic              ex_done,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              instr_valid,
    output logic [3:0]        opcode,
    output logic [5:0]        func_code,
    output logic [1:0]        read1,
    output logic [1:0]        read2,
    output logic [1:0]        write_reg,
    output logic [WORD_W-1:0] imm_ext,
    output logic [WORD_W-1:0] jmp_target,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] num_inst,
    output logic              halted
);

    import cpu_defs::*;

    localparam logic [WORD_W-1:0] ONE = {{(WORD_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] num_inst_q;
    logic              is_halt;

    instr_decoder #(.WORD_W(WORD_W)) u_decoder (
        .ir         (ir),
        .pc_hi      (pc_q[WORD_W-1:12]),
        .opcode     (opcode),
        .func_code  (func_code),
        .read1      (read1),
        .read2      (read2),
        .write_reg  (write_reg),
        .imm_ext    (imm_ext),
        .jmp_target (jmp_target)
    );

    assign is_halt = (opcode == OP_RTYPE) && (func_code == HLT_FUNC);

    // reset_n is an active-high asynchronous reset despite its name
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state      <= S_IDLE;
            pc_q       <= RESET_PC[WORD_W-1:0];
            ir         <= '0;
            num_inst_q <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (input_ready) begin
                        ir    <= data;
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ex_done) begin
                        num_inst_q <= num_inst_q + ONE;
                        // a retiring halt freezes pc even if a branch is flagged
                        if (is_halt) begin
                            state <= S_HALT;
                        end else begin
                            state <= S_FETCH;
                            pc_q  <= branch_taken ? branch_target : pc_q + ONE;
                        end
                    end
                end
                default: state <= S_HALT;
            endcase
        end
    end

    assign read_m      = (state == S_FETCH);
    assign instr_valid = (state == S_ISSUE);
    assign halted      = (state == S_HALT);
    assign address     = pc_q;
    assign pc          = pc_q;
    assign num_inst    = num_inst_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - scoreboard bench for fetch_decode_unit with directed instruction vectors
module tb_fetch_decode_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read_m;
    logic [15:0] address;
    logic [15:0] data;
    logic        input_ready;
    logic        ex_done;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [5:0]  func_code;
    logic [1:0]  read1, read2, write_reg;
    logic [15:0] imm_ext, jmp_target, pc, num_inst;
    logic        halted;

    always #5 clk = ~clk;

    fetch_decode_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .read_m        (read_m),
        .address       (address),
        .data          (data),
        .input_ready   (input_ready),
        .ex_done       (ex_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .opcode        (opcode),
        .func_code     (func_code),
        .read1         (read1),
        .read2         (read2),
        .write_reg     (write_reg),
        .imm_ext       (imm_ext),
        .jmp_target    (jmp_target),
        .pc            (pc),
        .num_inst      (num_inst),
        .halted        (halted)
    );

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  op;
        logic [5:0]  func;
        logic [1:0]  r1, r2, wr;
        logic [15:0] imm, jmp, ni;
    } issue_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] ni;
    } fetch_t;

    issue_t issue_q[$];
    fetch_t fetch_q[$];
    fetch_t halt_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // monitor: pops an expectation on each fetch start, issue start and halt entry
    initial begin
        logic   pr, pi, ph;
        issue_t e;
        fetch_t f;
        pr = 1'b0; pi = 1'b0; ph = 1'b0;
        forever begin
            @(negedge clk);
            if (read_m && !pr) begin
                check("fetch_expected", fetch_q.size() != 0, 1);
                if (fetch_q.size() != 0) begin
                    f = fetch_q.pop_front();
                    check("fetch_addr", address, f.addr);
                    check("fetch_num_inst", num_inst, f.ni);
                end
            end
            if (instr_valid && !pi) begin
                check("issue_expected", issue_q.size() != 0, 1);
                if (issue_q.size() != 0) begin
                    e = issue_q.pop_front();
                    check("issue_pc", pc, e.pc);
                    check("issue_opcode", opcode, e.op);
                    check("issue_func", func_code, e.func);
                    check("issue_read1", read1, e.r1);
                    check("issue_read2", read2, e.r2);
                    check("issue_write_reg", write_reg, e.wr);
                    check("issue_imm_ext", imm_ext, e.imm);
                    check("issue_jmp_target", jmp_target, e.jmp);
                    check("issue_num_inst", num_inst, e.ni);
                    check("issue_read_m", read_m, 0);
                end
            end
            if (halted && !ph) begin
                check("halt_expected", halt_q.size() != 0, 1);
                if (halt_q.size() != 0) begin
                    f = halt_q.pop_front();
                    check("halt_pc", pc, f.addr);
                    check("halt_num_inst", num_inst, f.ni);
                    check("halt_read_m", read_m, 0);
                    check("halt_instr_valid", instr_valid, 0);
                end
            end
            pr = read_m; pi = instr_valid; ph = halted;
        end
    end

    task automatic do_fetch(input logic [15:0] instr, input int nwait, input issue_t exp, output int waited);
        logic [15:0] a0;
        int k;
        k = 0;
        @(negedge clk);
        while (!read_m && k < 50) begin
            @(negedge clk);
            k++;
        end
        waited = k;
        check("fetch_seen", read_m, 1);
        a0 = address;
        for (int i = 0; i < nwait; i++) begin
            check("fetch_wait_addr", address, a0);
            check("fetch_wait_read_m", read_m, 1);
            check("fetch_wait_iv", instr_valid, 0);
            ex_done = (i % 2 == 1);
            @(negedge clk);
        end
        if (nwait > 0) check("fetch_pc_after_wait", pc, a0);
        ex_done = 1'b0;
        issue_q.push_back(exp);
        data = instr;
        input_ready = 1'b1;
        @(posedge clk);
        #1;
        input_ready = 1'b0;
        data = 16'h0BAD;
    endtask

    task automatic do_retire(input int nwait, input logic br, input logic [15:0] tgt,
                             input logic halt, input logic [15:0] exp_addr, input logic [15:0] exp_ni);
        logic [15:0] j0;
        logic [1:0]  w0;
        fetch_t f;
        j0 = jmp_target;
        w0 = write_reg;
        repeat (nwait) begin
            @(negedge clk);
            input_ready = 1'b1;
        end
        @(negedge clk);
        input_ready = 1'b0;
        check("issue_hold_iv", instr_valid, 1);
        check("issue_hold_jmp", jmp_target, j0);
        check("issue_hold_wr", write_reg, w0);
        f.addr = exp_addr;
        f.ni   = exp_ni;
        if (halt) halt_q.push_back(f);
        else fetch_q.push_back(f);
        ex_done = 1'b1;
        branch_taken = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
        ex_done = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        fetch_t f0;
        f0.addr = 16'h0000;
        f0.ni   = 16'h0000;
        reset_n = 1'b1;
        data = 16'h0000;
        input_ready = 1'b0;
        ex_done = 1'b0;
        branch_taken = 1'b0;
        branch_target = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst_read_m", read_m, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_address", address, 16'h0000);
        check("rst_pc", pc, 16'h0000);
        check("rst_num_inst", num_inst, 16'h0000);
        check("rst_opcode", opcode, 4'h0);
        check("rst_read1", read1, 2'd0);
        check("rst_read2", read2, 2'd0);
        check("rst_write_reg", write_reg, 2'd0);
        check("rst_imm_ext", imm_ext, 16'h0000);

        fetch_q.push_back(f0);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("idle_read_m", read_m, 0);

        do_fetch(16'hF1C0, 0, '{16'h0000, 4'hF, 6'h00, 2'd0, 2'd1, 2'd3, 16'hFFC0, 16'h01C0, 16'd0}, w);
        check("first_fetch_latency", w, 0);
        @(negedge clk);
        check("issue_next_cycle", instr_valid, 1);
        do_retire(2, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'd1);

        do_fetch(16'h46FE, 5, '{16'h0001, 4'h4, 6'h3E, 2'd1, 2'd2, 2'd2, 16'hFFFE, 16'h06FE, 16'd1}, w);
        do_retire(0, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'd2);

        do_fetch(16'h1234, 1, '{16'h0040, 4'h1, 6'h34, 2'd0, 2'd2, 2'd2, 16'h0034, 16'h0234, 16'd2}, w);
        do_retire(1, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF, 16'd3);

        do_fetch(16'hF6A5, 0, '{16'hFFFF, 4'hF, 6'h25, 2'd1, 2'd2, 2'd2, 16'hFFA5, 16'hF6A5, 16'd3}, w);
        do_retire(0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'd4);

        do_fetch(16'hF01D, 2, '{16'h0000, 4'hF, 6'h1D, 2'd0, 2'd0, 2'd0, 16'h001D, 16'h001D, 16'd4}, w);
        do_retire(0, 1'b1, 16'h0055, 1'b1, 16'h0000, 16'd5);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            input_ready = i[0];
            ex_done = ~i[0];
            branch_taken = 1'b1;
            branch_target = 16'h0077;
        end
        @(negedge clk);
        input_ready = 1'b0; ex_done = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
        check("halt_hold_halted", halted, 1);
        check("halt_hold_read_m", read_m, 0);
        check("halt_hold_iv", instr_valid, 0);
        check("halt_hold_pc", pc, 16'h0000);
        check("halt_hold_num_inst", num_inst, 16'd5);

        @(negedge clk);
        reset_n = 1'b1;
        #1 check("halt_rst_halted", halted, 0);
        fetch_q.push_back(f0);
        @(posedge clk);
        #1 reset_n = 1'b0;

        do_fetch(16'h46FE, 0, '{16'h0000, 4'h4, 6'h3E, 2'd1, 2'd2, 2'd2, 16'hFFFE, 16'h06FE, 16'd0}, w);
        do_retire(0, 1'b1, 16'h0040, 1'b0, 16'h0040, 16'd1);
        do_fetch(16'h1234, 0, '{16'h0040, 4'h1, 6'h34, 2'd0, 2'd2, 2'd2, 16'h0034, 16'h0234, 16'd1}, w);

        @(negedge clk);
        #2 reset_n = 1'b1;
        #1;
        check("async_rst_iv", instr_valid, 0);
        check("async_rst_read_m", read_m, 0);
        check("async_rst_pc", pc, 16'h0000);
        check("async_rst_address", address, 16'h0000);
        check("async_rst_num_inst", num_inst, 16'h0000);
        check("async_rst_opcode", opcode, 4'h0);
        check("async_rst_imm_ext", imm_ext, 16'h0000);
        fetch_q.push_back(f0);
        @(posedge clk);
        #1 reset_n = 1'b0;

        do_fetch(16'hF1C0, 0, '{16'h0000, 4'hF, 6'h00, 2'd0, 2'd1, 2'd3, 16'hFFC0, 16'h01C0, 16'd0}, w);
        do_retire(0, 1'b0, 16'h0000, 1'b0, 16'h0001, 16'd1);

        repeat (3) @(negedge clk);
        check("issue_q_drained", issue_q.size(), 0);
        check("fetch_q_drained", fetch_q.size(), 0);
        check("halt_q_drained", halt_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
